// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: synchronises locked_in, holds downstream reset until lock is stable for SETTLE_CYCLES.
// Optional macro LOCK_LOSS_COUNT_EN builds the saturating lost_count register (otherwise tied to 0).
module pll_lock_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             locked_in,
  input  logic             force_reset,
  output logic             rst_out,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] lost_count
);

  localparam int MAX_CYCLES = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int CTR_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CTR_W-1:0] SETTLE_LAST = CTR_W'(SETTLE_CYCLES - 1);
  localparam logic [CTR_W-1:0] HOLD_LAST   = CTR_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    RUN,
    HOLD
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_t                 state;
  logic [CTR_W-1:0]       ctr;

  // NOTE: every flop here uses non-blocking assignment so all registers update from pre-edge values.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_in};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Outputs change only on transitions into or out of RUN, so they track the next state exactly.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state     <= WAIT_LOCK;
      ctr       <= '0;
      rst_out   <= 1'b1;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      unique case (state)
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= SETTLE;
            ctr   <= '0;
          end
        end
        SETTLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else if (ctr == SETTLE_LAST) begin
            state   <= RUN;
            rst_out <= 1'b0;
            ready   <= 1'b1;
          end else begin
            ctr <= ctr + CTR_W'(1);
          end
        end
        RUN: begin
          if (!lock_s || force_reset) begin
            state     <= HOLD;
            ctr       <= '0;
            rst_out   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= !lock_s;
          end
        end
        HOLD: begin
          if (ctr == HOLD_LAST) begin
            state <= WAIT_LOCK;
          end else begin
            ctr <= ctr + CTR_W'(1);
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

`ifdef LOCK_LOSS_COUNT_EN
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      lost_count <= '0;
    end else if (state == RUN && !lock_s && lost_count != '1) begin
      lost_count <= lost_count + CNT_W'(1);
    end
  end
`else
  assign lost_count = '0;
`endif

endmodule
